pipelined_shifter: RTL and testbench
====================================

// Module: pipelined_shifter
// PURPOSE
//  Parametrised, pipelined multi-mode shifter: SLL/SRL/SRA (+ROL when enabled) on an N-bit word.
//  Logarithmic structure: stage k conditionally shifts by 2^k; one register per stage.
//  Streams 1 op/cycle behind a valid/ready handshake; feeds ALU/datapath results back-end.
// PARAMETERS
//  N       32   data width; power of 2, >= 2
//  L       $clog2(N) (localparam)   stage count and latency in cycles; shamt width
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous reset, active-low
//  in_valid   in   1   input op valid
//  in_ready   out  1   pipeline accepts input this cycle
//  in_data    in   N   operand
//  in_shamt   in   L   shift amount, 0..N-1 unsigned
//  in_op      in   2   shifter_pkg::shift_op_t
//  out_valid  out  1   out_data valid
//  out_ready  in   1   consumer takes out_data this cycle
//  out_data   out  N   result
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valid bits, data, op and shamt regs -> 0; out_valid=0,
//    out_data=0. In-flight ops are dropped; no stale result emerges after release.
//  - advance = !out_valid || out_ready; in_ready = advance (combinational, same cycle).
//  - On advance, every stage register loads from its predecessor; stage 0 loads
//    {in_valid, in_data, in_shamt, in_op}. Transfer in = in_valid && in_ready.
//  - !advance: whole pipeline holds (global stall); out_data/out_valid stable until taken.
//  - Bubbles are not compressed; they propagate as valid=0 slots.
//  - Latency exactly L cycles from input transfer to out_valid, with out_ready held 1.
//    Throughput 1 op/cycle; order preserved.
//  - Stage k: if shamt[k], shift by 2^k per op; else pass through unchanged.
//    SLL: zero fill at LSBs. SRL: zero fill at MSBs.
//    SRA: fill with bit N-1 of the ORIGINAL operand; the sign bit is carried through the
//      stages, not re-read.
//    ROL: bits leaving the MSB re-enter at the LSB.
//  - shamt=0: out_data == in_data for all ops. shamt=N-1: SLL leaves only bit 0 in the MSB.
//  - Op encoding lives in shifter_pkg; an unused or illegal op behaves as SLL.
// CONFIGURATION
//  SHIFTER_ROTATE_EN defined: SHIFT_ROL supported as above.
//  SHIFTER_ROTATE_EN undefined: no rotate logic; SHIFT_ROL decodes as SLL.
//  Handshake and latency are identical in both builds.
// STRUCTURE
//  - shifter_pkg:
//    - typedef enum logic [1:0] shift_op_t {SHIFT_SLL=0, SHIFT_SRL=1, SHIFT_SRA=2, SHIFT_ROL=3}
//    - function shamt_width(N)
//  - Sub-module shifter_stage #(N, K):
//    - combinational shift-by-2^K of {data, sign, op}, plus its stage register with enable=advance
//    - instantiated L times via generate
//  - Top holds the handshake/advance logic and the output mapping.
// TESTING (N=32, L=5, out_ready=1 unless stated)
//  1. SLL 0x0000_0001, shamt 31 -> out_data 0x8000_0000, out_valid exactly 5 cycles after accept.
//  2. 0x8000_0000, shamt 4: SRA -> 0xF800_0000; SRL -> 0x0800_0000.
//     0x7FFF_FFFF SRA 31 -> 0x0000_0000.
//  3. ROL 0x8000_0001, shamt 1 -> 0x0000_0003 with SHIFTER_ROTATE_EN;
//     -> 0x0000_0002 without it.
//  4. 64 back-to-back random ops, out_ready random 50%:
//     - scoreboard vs. reference model; no loss, duplication or reordering
//     - in_ready == (!out_valid || out_ready) every cycle
//  5. shamt 0 on every op with data 0xDEAD_BEEF -> 0xDEAD_BEEF each.
//  6. 3 ops in flight, rst_n pulsed low mid-cycle:
//     - out_valid=0 and out_data=0 immediately (async)
//     - no output for 5 cycles after release
//     - next accepted op returns correct result

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types for the pipelined shifter: op encoding and shift-amount width helper.
// Purely declarative; no logic, latency or flow control of its own.
package shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'd0,
    SHIFT_SRL = 2'd1,
    SHIFT_SRA = 2'd2,
    SHIFT_ROL = 2'd3
  } shift_op_t;

  function automatic int shamt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shifter_stage.sv
// One log-shifter stage: shift by 2^K when shamt[K] is set, then register; 1 cycle latency.
// Register loads only when en (pipeline advance) is high, else holds. Rotate gated by SHIFTER_ROTATE_EN.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 0,
  parameter int L = shamt_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         i_vld,
  input  logic [N-1:0] i_dat,
  input  logic         i_sign,
  input  shift_op_t    i_op,
  input  logic [L-1:0] i_shamt,
  output logic         o_vld,
  output logic [N-1:0] o_dat,
  output logic         o_sign,
  output shift_op_t    o_op,
  output logic [L-1:0] o_shamt
);

  localparam int S = 1 << K;

  logic [N-1:0] w_shifted;
  logic [N-1:0] w_next;

  logic         r_vld;
  logic [N-1:0] r_dat;
  logic         r_sign;
  shift_op_t    r_op;
  logic [L-1:0] r_shamt;

  // SRA fills from the carried sign of the original operand, not from i_dat's current MSB.
  always_comb begin
    w_shifted = i_dat << S;
    case (i_op)
      SHIFT_SRL: w_shifted = i_dat >> S;
      SHIFT_SRA: w_shifted = (i_dat >> S) | ({N{i_sign}} << (N - S));
`ifdef SHIFTER_ROTATE_EN
      SHIFT_ROL: w_shifted = (i_dat << S) | (i_dat >> (N - S));
`endif
      default:   w_shifted = i_dat << S;
    endcase
    w_next = i_shamt[K] ? w_shifted : i_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_dat   <= '0;
      r_sign  <= 1'b0;
      r_op    <= SHIFT_SLL;
      r_shamt <= '0;
    end else if (en) begin
      r_vld   <= i_vld;
      r_dat   <= w_next;
      r_sign  <= i_sign;
      r_op    <= i_op;
      r_shamt <= i_shamt;
    end
  end

  assign o_vld   = r_vld;
  assign o_dat   = r_dat;
  assign o_sign  = r_sign;
  assign o_op    = r_op;
  assign o_shamt = r_shamt;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRL/SRA(/ROL with SHIFTER_ROTATE_EN) shifter, 1 op/cycle, latency L=$clog2(N).
// Global stall: whole pipe holds while out_valid && !out_ready; in_ready mirrors advance.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter  int N = 32,
  localparam int L = shamt_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [L-1:0] in_shamt,
  input  shift_op_t    in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  logic         w_advance;
  logic         w_vld   [0:L];
  logic [N-1:0] w_dat   [0:L];
  logic         w_sign  [0:L];
  shift_op_t    w_op    [0:L];
  logic [L-1:0] w_shamt [0:L];
  logic         w_unused_tail;

  assign w_vld[0]   = in_valid;
  assign w_dat[0]   = in_data;
  assign w_sign[0]  = in_data[N-1];
  assign w_op[0]    = in_op;
  assign w_shamt[0] = in_shamt;

  generate
    for (genvar k = 0; k < L; k++) begin : g_stage
      shifter_stage #(
        .N (N),
        .K (k),
        .L (L)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (w_advance),
        .i_vld   (w_vld[k]),
        .i_dat   (w_dat[k]),
        .i_sign  (w_sign[k]),
        .i_op    (w_op[k]),
        .i_shamt (w_shamt[k]),
        .o_vld   (w_vld[k+1]),
        .o_dat   (w_dat[k+1]),
        .o_sign  (w_sign[k+1]),
        .o_op    (w_op[k+1]),
        .o_shamt (w_shamt[k+1])
      );
    end
  endgenerate

  // Side-band fields are dead once the last stage has been applied.
  assign w_unused_tail = ^{w_sign[L], w_op[L], w_shamt[L]};

  assign out_valid = w_vld[L];
  assign out_data  = w_dat[L];
  assign w_advance = !w_vld[L] || out_ready;
  assign in_ready  = w_advance;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter (N=32, L=5): directed vectors, random stream, async reset.
module tb_pipelined_shifter;
  import shifter_pkg::*;

  localparam int N = 32;
  localparam int L = 5;

`ifdef SHIFTER_ROTATE_EN
  localparam logic [31:0] ROL_EXP = 32'h0000_0003;
`else
  localparam logic [31:0] ROL_EXP = 32'h0000_0002;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  shift_op_t   in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  pipelined_shifter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    int          acc;
    bit          chk_lat;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_shift(input shift_op_t op, input logic [31:0] d,
                                            input logic [4:0] sh);
    case (op)
      SHIFT_SRL: return d >> sh;
      SHIFT_SRA: return 32'($signed(d) >>> sh);
`ifdef SHIFTER_ROTATE_EN
      SHIFT_ROL: return (d << sh) | (d >> (6'd32 - {1'b0, sh}));
`endif
      default:   return d << sh;
    endcase
  endfunction

  // Monitor: handshake rule every cycle, pop-and-compare on each output transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", out_data, 32'hxxxx_xxxx);
        end else begin
          mon_e = sb.pop_front();
          check("data", out_data, mon_e.exp);
          if (mon_e.chk_lat) check("latency", 32'(cyc - mon_e.acc), 32'(L));
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input shift_op_t op, input logic [31:0] d, input logic [4:0] sh,
                      input logic [31:0] exp, input bit chk_lat);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{exp, cyc, chk_lat});
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    shift_op_t   op;
    logic [31:0] d;
    logic [4:0]  sh;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = SHIFT_SLL;
    out_ready = 1'b1;
    #2;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    #21 rst_n = 1'b1;

    // Directed vectors, out_ready held high so latency must be exactly L.
    send(SHIFT_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b1);
    idle();
    drain();

    send(SHIFT_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b1);
    send(SHIFT_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b1);
    send(SHIFT_SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1);
    send(SHIFT_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b1);
    send(SHIFT_SLL, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b1);
    send(SHIFT_SRL, 32'hF000_000F, 5'd7,  32'h01E0_0000, 1'b1);
    send(SHIFT_ROL, 32'h8000_0001, 5'd1,  ROL_EXP,       1'b1);
    idle();
    drain();

    send(SHIFT_SLL, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b1);
    send(SHIFT_SRL, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b1);
    send(SHIFT_SRA, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b1);
    send(SHIFT_ROL, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b1);
    idle();
    drain();

    // Random stream with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      op = shift_op_t'($urandom_range(0, 3));
      d  = $urandom;
      sh = 5'($urandom_range(0, 31));
      send(op, d, sh, ref_shift(op, d, sh), 1'b0);
    end
    idle();
    drain();
    rand_rdy = 1'b0;
    idle();

    // Async reset with ops in flight: first op sits at the output when reset hits.
    send(SHIFT_SLL, 32'h0000_00FF, 5'd8, 32'h0000_FF00, 1'b0);
    send(SHIFT_SRL, 32'h1234_5678, 5'd4, 32'h0123_4567, 1'b0);
    send(SHIFT_SRA, 32'h8765_4321, 5'd8, 32'hFF87_6543, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_out_valid", {31'b0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_reset_out_data", out_data, 32'd0);
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      check("post_reset_quiet", {31'b0, out_valid}, 32'd0);
    end
    send(SHIFT_SRA, 32'hC000_0000, 5'd2, 32'hF000_0000, 1'b1);
    idle();
    drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
